// File: rtl/mvm_ctrl_pkg.sv
// rtl/mvm_ctrl_pkg.sv - shared state encoding and fixed-point helpers for the MVM iteration sequencer
package mvm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    function automatic longint fxp_one(input int frac_width);
        return longint'(1) << frac_width;
    endfunction

endpackage

// File: rtl/fxp_saturate.sv
// rtl/fxp_saturate.sv - combinational clamp of one signed fixed-point element to [-ONE, +ONE]
module fxp_saturate
    import mvm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic signed [DATA_WIDTH-1:0] data_o
);

    localparam logic signed [DATA_WIDTH-1:0] POS_ONE = DATA_WIDTH'(fxp_one(FRAC_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] NEG_ONE = -POS_ONE;

    always_comb begin
        data_o = data_i;
        if (data_i > POS_ONE) begin
            data_o = POS_ONE;
        end else if (data_i < NEG_ONE) begin
            data_o = NEG_ONE;
        end
    end

endmodule

// File: rtl/mvm_iter_ctrl.sv
// rtl/mvm_iter_ctrl.sv - issues the spin vector to the multiplier, saturates the product and iterates
module mvm_iter_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int ITER_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ITER_WIDTH-1:0]      num_iters,
    input  logic [N*DATA_WIDTH-1:0]    x_init,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ITER_WIDTH-1:0]      iter_count,
    output logic [N*DATA_WIDTH-1:0]    x_out,
    output logic                       mvm_valid_in,
    output logic [N*DATA_WIDTH-1:0]    mvm_x,
    input  logic [N*DATA_WIDTH-1:0]    mvm_result,
    input  logic                       mvm_valid_out
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    ctrl_state_e             state_q, state_d;
    logic [N*DATA_WIDTH-1:0] x_q, x_d, x_sat;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d, n_q, n_d, iter_inc;
    logic                    error_q, error_d;
    logic [WCW-1:0]          wait_q, wait_d, wait_inc;
    logic                    timeout_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_sat
        fxp_saturate #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH)
        ) u_sat (
            .data_i(mvm_result[gi*DATA_WIDTH +: DATA_WIDTH]),
            .data_o(x_sat[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign iter_inc    = iter_q + 1'b1;
    assign wait_inc    = wait_q + 1'b1;
    // Fires on the WAIT cycle whose increment would reach TIMEOUT-1; a valid in that cycle still wins.
    assign timeout_hit = (32'(wait_inc) >= 32'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        iter_d  = iter_q;
        n_d     = n_q;
        error_d = error_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_init;
                    iter_d  = '0;
                    n_d     = num_iters;
                    error_d = 1'b0;
                    wait_d  = '0;
                    state_d = (num_iters == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (mvm_valid_out) begin
                    x_d     = x_sat;
                    iter_d  = iter_inc;
                    state_d = (iter_inc == n_q) ? DONE : ISSUE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            iter_q  <= '0;
            n_q     <= '0;
            error_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            iter_q  <= iter_d;
            n_q     <= n_d;
            error_q <= error_d;
            wait_q  <= wait_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign mvm_valid_in = (state_q == ISSUE);
    assign error        = error_q;
    assign iter_count   = iter_q;
    assign x_out        = x_q;
    assign mvm_x        = x_q;

endmodule

// File: tb/tb_mvm_iter_ctrl.sv
// tb/tb_mvm_iter_ctrl.sv - self-checking bench for mvm_iter_ctrl with a behavioural 2x2 multiplier stub
module tb_mvm_iter_ctrl;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int IW = 16;

    logic            clk, rst, start, abort;
    logic [IW-1:0]   num_iters;
    logic [N*DW-1:0] x_init, x_out, mvm_x, mvm_result;
    logic            busy, done, error, mvm_valid_in, mvm_valid_out;
    logic [IW-1:0]   iter_count;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Stub configuration: 2x2 integer J (row-major), latency in cycles, 0 = never answers.
    int st_j[4];
    int st_lat;
    int st_cnt;

    typedef struct {
        int          j00, j01, j10, j11;
        logic [31:0] x0, x1;
        int          n, lat;
        logic [31:0] e0, e1;
        int          eiter;
        int          eerr;
        int          edone;
        int          eissue;
    } vec_t;

    vec_t tbl[9];
    vec_t sb_q[$];

    mvm_iter_ctrl #(
        .N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(16), .ITER_WIDTH(IW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_iters(num_iters), .x_init(x_init),
        .busy(busy), .done(done), .error(error), .iter_count(iter_count),
        .x_out(x_out), .mvm_valid_in(mvm_valid_in), .mvm_x(mvm_x),
        .mvm_result(mvm_result), .mvm_valid_out(mvm_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mult(input logic [63:0] xv);
        longint a, b, y0, y1;
        a  = longint'($signed(xv[31:0]));
        b  = longint'($signed(xv[63:32]));
        y0 = longint'(st_j[0]) * a + longint'(st_j[1]) * b;
        y1 = longint'(st_j[2]) * a + longint'(st_j[3]) * b;
        return {y1[31:0], y0[31:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mvm_valid_out <= 1'b0;
            mvm_result    <= '0;
            st_cnt        <= 0;
        end else begin
            mvm_valid_out <= 1'b0;
            if (mvm_valid_in && st_lat != 0) begin
                mvm_result    <= mult(mvm_x);
                st_cnt        <= st_lat - 1;
                mvm_valid_out <= (st_lat == 1);
            end else if (st_cnt != 0) begin
                st_cnt        <= st_cnt - 1;
                mvm_valid_out <= (st_cnt == 1);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_j(input int a, input int b, input int c, input int d);
        st_j[0] = a; st_j[1] = b; st_j[2] = c; st_j[3] = d;
    endtask

    task automatic run_case(input int k);
        vec_t v;
        int   t0, issues, c;
        v = tbl[k];
        @(negedge clk);
        set_j(v.j00, v.j01, v.j10, v.j11);
        st_lat    = v.lat;
        x_init    = {v.x1, v.x0};
        num_iters = IW'(v.n);
        start     = 1'b1;
        t0        = cyc;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("c%0d_busy_after_start", k), busy, 1);
        chk($sformatf("c%0d_error_cleared", k), error, 0);
        issues = 0;
        c      = 0;
        while (!done && c < 200) begin
            if (mvm_valid_in) issues++;
            @(negedge clk);
            c++;
        end
        chk($sformatf("c%0d_done_seen", k), done, 1);
        v = sb_q.pop_front();
        if (done) begin
            chk($sformatf("c%0d_done_cycle", k), 64'(cyc - t0), 64'(v.edone));
            chk($sformatf("c%0d_x_out", k), x_out, {v.e1, v.e0});
            chk($sformatf("c%0d_mvm_x", k), mvm_x, {v.e1, v.e0});
            chk($sformatf("c%0d_iter_count", k), iter_count, 64'(v.eiter));
            chk($sformatf("c%0d_error", k), error, 64'(v.eerr));
            chk($sformatf("c%0d_issue_pulses", k), 64'(issues), 64'(v.eissue));
            @(negedge clk);
            chk($sformatf("c%0d_done_one_cycle", k), {done, busy}, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    int t0, dones, c;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_iters = '0; x_init = '0;
        st_lat = 1;
        set_j(1, 0, 0, 1);

        tbl[0] = '{1, 0, 0, 1, 32'h0000_8000, 32'hFFFF_C000, 3, 1, 32'h0000_8000, 32'hFFFF_C000, 3, 0, 7, 3};
        tbl[1] = '{2, 0, 0, 2, 32'h0000_8000, 32'hFFFF_C000, 3, 1, 32'h0001_0000, 32'hFFFF_0000, 3, 0, 7, 3};
        tbl[2] = '{1, 0, 0, 1, 32'h0000_1234, 32'hFFFF_FFFB, 0, 1, 32'h0000_1234, 32'hFFFF_FFFB, 0, 0, 1, 0};
        tbl[3] = '{0, 1, 1, 0, 32'h0000_7000, 32'hFFFF_E000, 3, 3, 32'hFFFF_E000, 32'h0000_7000, 3, 0, 13, 3};
        tbl[4] = '{1, 0, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 32'hFFFF_0000, 32'h0001_0000, 1, 0, 3, 1};
        tbl[5] = '{1, 0, 0, 1, 32'h0001_0001, 32'hFFFF_0000, 1, 2, 32'h0001_0000, 32'hFFFF_0000, 1, 0, 4, 1};
        tbl[6] = '{1, 0, 0, 1, 32'h0000_0011, 32'h0000_0022, 2, 0, 32'h0000_0011, 32'h0000_0022, 0, 1, 17, 1};
        tbl[7] = '{1, 0, 0, 1, 32'h0001_0000, 32'hFFFE_FFFF, 1, 15, 32'h0001_0000, 32'hFFFF_0000, 1, 0, 17, 1};
        tbl[8] = '{1, 1, 1, -1, 32'h0000_6000, 32'h0000_2000, 2, 1, 32'h0000_C000, 32'h0000_4000, 2, 0, 5, 2};

        repeat (2) @(negedge clk);
        chk("reset_flags", {busy, done, error, mvm_valid_in}, 0);
        chk("reset_iter_count", iter_count, 0);
        chk("reset_x_out", x_out, 0);
        chk("reset_mvm_x", mvm_x, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, mvm_valid_in}, 0);

        for (int k = 0; k < 9; k++) run_case(k);

        // Abort in the first cycle of the second WAIT.
        @(negedge clk);
        set_j(1, 0, 0, 1); st_lat = 3;
        x_init = {32'h0000_0200, 32'h0000_0100}; num_iters = 16'd3; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        chk("abort_pre_state", {busy, mvm_valid_in, iter_count}, {2'b10, 16'd1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_next", {busy, done}, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dones), 0);
        chk("abort_iter_hold", iter_count, 1);
        chk("abort_x_hold", x_out, {32'h0000_0200, 32'h0000_0100});
        chk("abort_error_hold", error, 0);

        // Asynchronous reset in WAIT.
        set_j(2, 0, 0, 2); st_lat = 3;
        x_init = {32'h0000_0300, 32'h0000_0400}; num_iters = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", {busy, x_out}, {1'b1, 32'h0000_0300, 32'h0000_0400});
        #2 rst = 1'b1;
        #1;
        chk("rst_async_flags", {busy, done, error, mvm_valid_in}, 0);
        chk("rst_async_iter", iter_count, 0);
        chk("rst_async_x", {x_out, mvm_x}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("rst_no_done", 64'(dones), 0);

        // Second start while busy is ignored.
        set_j(1, 0, 0, 1); st_lat = 1;
        x_init = {32'h0000_0001, 32'h0000_0002}; num_iters = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        num_iters = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("restart_single_done", 64'(dones), 1);
        chk("restart_iter_count", iter_count, 2);

        // start and abort together in IDLE: start wins.
        x_init = {32'h0000_0005, 32'h0000_0006}; num_iters = 16'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_accept", {busy, mvm_valid_in}, 2'b11);
        c = 0;
        while (!done && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("start_abort_done", {done, iter_count}, {1'b1, 16'd1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
